morse_char_assembler: RTL

Sequencing and buffering stage placed directly after the Morse decoder. It consumes the decoder's single-cycle dot/dash/letter-gap/word-gap pulses and assembles symbols into a code word. On each gap it looks up the ASCII character for that code word and pushes it into a small output FIFO. A downstream consumer, such as a UART TX or display driver, drains the FIFO through a valid/ready handshake.

---
 rtl/morse_pkg.sv | 84 ++++++++
 rtl/morse_char_assembler_if.sv | 9 +
 rtl/morse_char_fifo.sv | 60 ++++++
 rtl/morse_char_assembler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types, FSM state encodings and the Morse-to-ASCII lookup for the
// character assembler. Define MORSE_DIGITS_EN to decode 5-symbol digit codes.
package morse_pkg;

  localparam int unsigned MAX_SYMBOLS = 5;

  typedef logic [4:0] code_t;  // dot=0, dash=1, newest symbol in the LSB
  typedef logic [2:0] len_t;
  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StCollect  = 2'd1;
  localparam state_t StOverflow = 2'd2;
  localparam state_t StSpace    = 2'd3;

  // Bits of code above len are always zero, so the low len bits fully identify the letter.
  function automatic logic [7:0] morse_lookup(input code_t code, input len_t len,
                                              input logic [7:0] invalid_char);
    logic [7:0] ch;
    ch = invalid_char;
    case (len)
      3'd1: ch = code[0] ? 8'h54 : 8'h45;  // T E
      3'd2: begin
        case (code[1:0])
          2'b00:   ch = 8'h49;  // I
          2'b01:   ch = 8'h41;  // A
          2'b10:   ch = 8'h4E;  // N
          default: ch = 8'h4D;  // M
        endcase
      end
      3'd3: begin
        case (code[2:0])
          3'b000:  ch = 8'h53;  // S
          3'b001:  ch = 8'h55;  // U
          3'b010:  ch = 8'h52;  // R
          3'b011:  ch = 8'h57;  // W
          3'b100:  ch = 8'h44;  // D
          3'b101:  ch = 8'h4B;  // K
          3'b110:  ch = 8'h47;  // G
          default: ch = 8'h4F;  // O
        endcase
      end
      3'd4: begin
        case (code[3:0])
          4'b0000: ch = 8'h48;  // H
          4'b0001: ch = 8'h56;  // V
          4'b0010: ch = 8'h46;  // F
          4'b0100: ch = 8'h4C;  // L
          4'b0110: ch = 8'h50;  // P
          4'b0111: ch = 8'h4A;  // J
          4'b1000: ch = 8'h42;  // B
          4'b1001: ch = 8'h58;  // X
          4'b1010: ch = 8'h43;  // C
          4'b1011: ch = 8'h59;  // Y
          4'b1100: ch = 8'h5A;  // Z
          4'b1101: ch = 8'h51;  // Q
          default: ch = invalid_char;
        endcase
      end
`ifdef MORSE_DIGITS_EN
      3'd5: begin
        case (code)
          5'b11111: ch = 8'h30;
          5'b01111: ch = 8'h31;
          5'b00111: ch = 8'h32;
          5'b00011: ch = 8'h33;
          5'b00001: ch = 8'h34;
          5'b00000: ch = 8'h35;
          5'b10000: ch = 8'h36;
          5'b11000: ch = 8'h37;
          5'b11100: ch = 8'h38;
          5'b11110: ch = 8'h39;
          default:  ch = invalid_char;
        endcase
      end
`else
      3'd5: ch = invalid_char;
`endif
      default: ch = invalid_char;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/morse_char_assembler_if.sv
// Byte stream from the assembler to its consumer (valid/ready, show-ahead data).
interface morse_char_assembler_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/morse_char_fifo.sv
// Synchronous show-ahead FIFO; a push while full only lands if a pop frees a slot
// in the same cycle. Head reads as zero while empty.
module morse_char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Assembles decoder dot/dash/gap pulses into ASCII bytes and buffers them in a
// small FIFO. Build option: MORSE_DIGITS_EN enables 5-symbol digit decoding.
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  INVALID_CHAR = 8'h3F,
  parameter logic [7:0]  SPACE_CHAR   = 8'h20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dot,
  input  logic                         dash,
  input  logic                         lg,
  input  logic                         wg,
  morse_char_assembler_if.master       out_if,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         drop_flag,
  input  logic                         clear_drop
);

  state_t     state_q, state_d;
  code_t      code_q, code_d;
  len_t       len_q, len_d;
  logic       armed_q, armed_d;
  logic       drop_q, drop_d;
  logic       push, pop, full, empty, sym_valid;
  logic [7:0] wdata;

  assign sym_valid         = dot ^ dash;  // simultaneous dot+dash is meaningless
  assign pop               = out_if.char_valid & out_if.char_ready;
  assign out_if.char_valid = ~empty;
  assign drop_flag         = drop_q;

  // Assembler FSM: collect symbols, emit one byte per gap, one space per word.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    armed_d = armed_q;
    push    = 1'b0;
    wdata   = SPACE_CHAR;
    case (state_q)
      StIdle: begin
        if (sym_valid) begin
          code_d  = {4'b0000, dash};
          len_d   = 3'd1;
          state_d = StCollect;
        end else if (wg) begin
          push    = armed_q;
          armed_d = 1'b0;
        end
      end
      StCollect: begin
        if (sym_valid) begin
          if (len_q == len_t'(MAX_SYMBOLS)) begin
            state_d = StOverflow;
          end else begin
            code_d = {code_q[3:0], dash};
            len_d  = len_q + 3'd1;
          end
        end else if (lg || wg) begin
          push    = 1'b1;
          wdata   = morse_lookup(code_q, len_q, INVALID_CHAR);
          code_d  = '0;
          len_d   = '0;
          state_d = wg ? StSpace : StIdle;
          if (!wg) armed_d = 1'b1;
        end
      end
      StOverflow: begin
        if (lg || wg) begin
          push    = 1'b1;
          wdata   = INVALID_CHAR;
          code_d  = '0;
          len_d   = '0;
          state_d = wg ? StSpace : StIdle;
          if (!wg) armed_d = 1'b1;
        end
      end
      StSpace: begin
        push    = 1'b1;
        armed_d = 1'b0;
        state_d = StIdle;
        // A symbol here already belongs to the next letter.
        if (sym_valid) begin
          code_d  = {4'b0000, dash};
          len_d   = 3'd1;
          state_d = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky overflow indication; a new drop wins over a simultaneous clear.
  always_comb begin
    drop_d = drop_q;
    if (push && full && !pop) drop_d = 1'b1;
    else if (clear_drop)      drop_d = 1'b0;
  end

  // Assembler and drop state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
      len_q   <= '0;
      armed_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      armed_q <= armed_d;
      drop_q  <= drop_d;
    end
  end

  morse_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (out_if.char_data),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
